reduce_accumulator: RTL and testbench

- Downstream consumer of the combinational adder tree.
- Accepts one scalar adder-tree sum per cycle over a valid/ready handshake.
- Accumulates a frame of frame_len sums into a wider accumulator, then presents the frame total on a valid/ready output.
- Sits between the vector reduction stage and the trace buffer in the debug datapath.

---
 rtl/reduce_accumulator_pkg.sv | 14 +
 rtl/reduce_accumulator_acc_add.sv | 25 ++
 rtl/reduce_accumulator.sv | 143 ++++++++++++++
 tb/tb_reduce_accumulator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reduce_accumulator_pkg.sv
// Shared types and sizing helpers for the reduce_accumulator frame summer.
package reduce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/reduce_accumulator_acc_add.sv
// Combinational accumulate step: acc + zero-extended data, wrapping by default
// or clamping at all-ones when REDUCE_ACCUMULATOR_SATURATE_EN is defined.
module acc_add #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  overflow
);

    logic [ACC_WIDTH:0] full;

    // One extra bit catches the carry out of the accumulator width.
    assign full     = {1'b0, acc} + (ACC_WIDTH + 1)'(data);
    assign overflow = full[ACC_WIDTH];

`ifdef REDUCE_ACCUMULATOR_SATURATE_EN
    assign sum = full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
    assign sum = full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/reduce_accumulator.sv
// Sums frames of frame_len adder-tree results and presents each total over valid/ready.
// Optional build macro REDUCE_ACCUMULATOR_SATURATE_EN: saturating sum plus sat_flag output.
module reduce_accumulator
    import reduce_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  ACC_WIDTH  = 40,
    parameter int  MAX_LEN    = 1024,
    localparam int CNT_WIDTH  = cnt_width(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CNT_WIDTH-1:0]  frame_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
`ifdef REDUCE_ACCUMULATOR_SATURATE_EN
    output logic                  sat_flag,
`endif
    output logic                  busy
);

    state_t                 state;
    state_t                 state_next;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   len_new;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   beat;
    logic                   first_beat;
    logic                   last_beat;

    // HOLD only frees the input when the held total is being taken this cycle.
    assign in_ready   = (state != HOLD) || out_ready;
    assign beat       = in_valid && in_ready;
    assign first_beat = (state != ACCUM);
    assign last_beat  = ((cnt + CNT_WIDTH'(1)) == len_q);

    always_comb begin
        len_new = frame_len;
        if (frame_len == '0) begin
            len_new = CNT_WIDTH'(1);
        end else if (frame_len > CNT_WIDTH'(MAX_LEN)) begin
            len_new = CNT_WIDTH'(MAX_LEN);
        end
    end

`ifdef REDUCE_ACCUMULATOR_SATURATE_EN
    logic ovf;
    logic sat_q;

    acc_add #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_add (
        .acc      (acc),
        .data     (in_data),
        .sum      (sum),
        .overflow (ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (beat) begin
            sat_q <= first_beat ? 1'b0 : (sat_q | ovf);
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_ovf;

    acc_add #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_add (
        .acc      (acc),
        .data     (in_data),
        .sum      (sum),
        .overflow (unused_ovf)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    state_next = (len_new == CNT_WIDTH'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                busy = 1'b1;
                if (beat && last_beat) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                // A beat here implies out_ready, so the next frame starts with no bubble.
                if (beat) begin
                    state_next = (len_new == CNT_WIDTH'(1)) ? HOLD : ACCUM;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= CNT_WIDTH'(1);
        end else if (beat) begin
            if (first_beat) begin
                acc   <= ACC_WIDTH'(in_data);
                cnt   <= CNT_WIDTH'(1);
                len_q <= len_new;
            end else begin
                acc   <= sum;
                cnt   <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    // The accumulator itself is the presented total; it only moves on a beat,
    // and HOLD accepts no beat without the handshake.
    assign out_data  = acc;
    assign out_count = cnt;

endmodule

// File: tb/tb_reduce_accumulator.sv
// Directed + random bench for reduce_accumulator against a frame-level reference model.
// Build with REDUCE_ACCUMULATOR_SATURATE_EN to exercise the saturating variant.
module tb_reduce_accumulator;

    localparam int DATA_WIDTH = 32;
    localparam int ACC_WIDTH  = 40;
    localparam int MAX_LEN    = 1024;
    localparam int CNT_W      = $clog2(MAX_LEN + 1);
    localparam logic [63:0] ACC_MAX = (64'd1 << ACC_WIDTH) - 64'd1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [CNT_W-1:0]      frame_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_data;
    logic [CNT_W-1:0]      out_count;
    logic                  busy;
`ifdef REDUCE_ACCUMULATOR_SATURATE_EN
    logic                  sat_flag;
`endif

    reduce_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
`ifdef REDUCE_ACCUMULATOR_SATURATE_EN
        .sat_flag  (sat_flag),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] total;
        int          count;
        bit          sat;
    } frame_t;

    int            errors = 0;
    int            checks = 0;
    logic [63:0]   beats[$];
    frame_t        pend[$];
    int            cur_len = 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame total from the list of accepted beats, using wide plain arithmetic.
    function automatic frame_t close_frame();
        frame_t      f;
        logic [63:0] s = 64'd0;
        foreach (beats[i]) s += beats[i];
        f.count = beats.size();
        f.sat   = (s > ACC_MAX);
`ifdef REDUCE_ACCUMULATOR_SATURATE_EN
        f.total = f.sat ? ACC_MAX : s;
`else
        f.total = s & ACC_MAX;
`endif
        return f;
    endfunction

    // One clock cycle: drive, check at mid-cycle, update model, advance past the edge.
    task automatic cyc(input logic v, input logic [31:0] d, input int fl, input logic ordy);
        logic exp_rdy;
        in_valid  = v;
        in_data   = d;
        frame_len = CNT_W'(fl);
        out_ready = ordy;
        #4;
        exp_rdy = (pend.size() == 0) || ordy;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, pend.size() != 0);
        chk("busy", busy, beats.size() != 0);
        if (pend.size() != 0) begin
            chk("out_data", out_data, pend[0].total);
            chk("out_count", out_count, pend[0].count);
`ifdef REDUCE_ACCUMULATOR_SATURATE_EN
            chk("sat_flag", sat_flag, pend[0].sat);
`endif
            if (ordy) void'(pend.pop_front());
        end
        if (v && exp_rdy) begin
            if (beats.size() == 0)
                cur_len = (fl == 0) ? 1 : ((fl > MAX_LEN) ? MAX_LEN : fl);
            beats.push_back(64'(d));
            if (beats.size() == cur_len) begin
                pend.push_back(close_frame());
                beats.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        frame_len = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // frame_len=4, 1..4, consumer stalls two cycles
        for (int i = 1; i <= 4; i++) cyc(1, i, 4, 0);
        cyc(0, 0, 4, 0);
        cyc(0, 0, 4, 0);
        cyc(0, 0, 4, 1);

        // frame_len=1 streaming with out_ready held
        cyc(1, 5, 1, 1);
        cyc(1, 6, 1, 1);
        cyc(1, 7, 1, 1);
        cyc(0, 0, 1, 1);

        // frame_len=3, held for 5 cycles, then release with a new beat
        for (int i = 0; i < 3; i++) cyc(1, 32'd100 + i, 3, 0);
        for (int i = 0; i < 5; i++) cyc(1, 32'hdead, 3, 0);
        cyc(1, 9, 3, 1);
        cyc(1, 10, 3, 1);
        cyc(1, 11, 3, 1);
        cyc(0, 0, 3, 1);

        // frame_len=0 behaves as 1
        cyc(1, 42, 0, 1);
        cyc(1, 43, 0, 1);
        cyc(0, 0, 0, 1);

        // frame_len changes 4->2 mid-frame
        cyc(1, 1, 4, 1);
        cyc(1, 2, 2, 1);
        cyc(1, 3, 2, 1);
        cyc(1, 4, 2, 1);
        cyc(1, 5, 2, 1);
        cyc(1, 6, 2, 1);
        cyc(0, 0, 2, 1);

        // reset after 2 of 4 beats (4+5=9), then a clean post-reset frame
        cyc(1, 4, 4, 1);
        cyc(1, 5, 4, 1);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_count", out_count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        beats.delete();
        pend.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1, 32'd20 + i, 4, 1);
        cyc(0, 0, 4, 1);

        // sum exceeds 2^ACC_WIDTH: wrap (or saturate)
        for (int i = 0; i < 300; i++) cyc(1, 32'hffff_ffff, 300, 1);
        cyc(0, 0, 300, 0);
        cyc(0, 0, 300, 1);
        // first beat after an overflowing frame starts clean
        cyc(1, 3, 2, 1);
        cyc(1, 4, 2, 1);
        cyc(0, 0, 2, 1);

        // frame_len above MAX_LEN clamps to MAX_LEN
        for (int i = 0; i < MAX_LEN; i++) cyc(1, $urandom, 2000, 1);
        cyc(0, 0, 2000, 1);

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 6),
                $urandom_range(0, 3) != 0);

        // bounded drain
        for (int i = 0; i < 20 && (pend.size() != 0 || beats.size() != 0); i++) begin
            if (beats.size() != 0) cyc(1, $urandom, 1, 1);
            else cyc(0, 0, 1, 1);
        end
        chk("drain_out_valid", out_valid, 0);
        chk("drain_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
